counter_ctrl: RTL and testbench
===============================

# counter_ctrl

Sequencing controller for the 16-bit count datapath. Accepts start/stop/pause/clear commands over a valid/ready handshake, paces the count with a programmable prescaler, and terminates or wraps at a programmable limit. It reports status (`busy`, `done`, `err`, wrap count) to the surrounding control logic.

## Interface
- `WIDTH`, 16: count and limit width.
- `PSW`, 8: prescale field width.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: controller can accept a command.
- `cmd_op`  in  2: 00 START, 01 STOP, 10 PAUSE (toggle pause/resume), 11 CLEAR.
- `cfg_limit`  in  WIDTH: terminal count, sampled on an accepted START.
- `cfg_mode`  in  1: 0 one-shot, 1 periodic; sampled on an accepted START.
- `cfg_prescale`  in  PSW: divide value P; one tick every P+1 cycles; sampled on an accepted START.
- `count`  out  WIDTH: current count.
- `busy`  out  1: state is RUN or PAUSED.
- `done`  out  1: one-cycle pulse at terminal count.
- `err`  out  1: one-cycle pulse when an illegal command is accepted.
- `wraps`  out  8: periodic completions, saturating at 255.

## Operation
- States: IDLE, RUN, PAUSED, DONE. Reset state is IDLE.
- Reset values: `count`=0, `wraps`=0, `done`=0, `err`=0, `busy`=0, `cmd_ready`=1. Prescaler `pc`=0. Latched config is 0.
- Accept: `cmd_valid & cmd_ready` at a rising edge. `cmd_ready` drops for exactly the one cycle after any acceptance, then returns to 1. Commands therefore have a minimum spacing of 2 cycles.
- START:
  - In IDLE/DONE: latch the cfg fields, set `count`=0, `pc`=0, `wraps`=0, go to RUN.
  - In RUN/PAUSED: no state change; pulse `err`.
- STOP: any state goes to IDLE. `count` and `wraps` hold.
- PAUSE:
  - RUN goes to PAUSED; `count` and `pc` freeze.
  - PAUSED goes to RUN, resuming from the frozen `pc`.
  - In IDLE/DONE: pulse `err` only.
- CLEAR: any state goes to IDLE with `count`=0, `wraps`=0, `pc`=0.
- Prescaler, in RUN only:
  - If `pc`==P: tick, and `pc` returns to 0.
  - Otherwise `pc` increments.
- On a tick with `count` < limit: `count`+1.
- On a tick with `count` == limit:
  - One-shot: go to DONE, `count` holds at limit, pulse `done`.
  - Periodic: `count` returns to 0, stay in RUN, pulse `done`, `wraps`+1 (saturating at 255).
- The sequence is 0..L, so the period is L+1 ticks. L=0 in one-shot finishes on the first tick. L=0 in periodic pulses `done` on every tick.
- All arithmetic is unsigned. `count` never exceeds the latched limit.
- `cfg_*` inputs are ignored except at START acceptance.

## Timing
- START accepted at edge N:
  - RUN and `busy`=1 from edge N.
  - `pc`=0 in the cycle after N.
  - First increment at edge N+P+2.
- Increments then follow every P+1 cycles.
- `done` and `err` are registered. They are high for the cycle following the edge that caused them.
- Example, P=0, L=3, one-shot, START at N:
  - `count` reaches 1/2/3 at N+2/N+3/N+4.
  - At edge N+5: DONE entered and `done` high for one cycle.
- Simultaneous events:
  - A command accepted on the same edge as a tick takes priority; the tick is discarded.
  - STOP, CLEAR or PAUSE on a terminal edge: `done` does not pulse.
- Asynchronous reset mid-run: all outputs reach their reset values immediately, with no `done` pulse.

## Configuration
- `COUNTER_CTRL_PRESCALE_EN`:
  - Defined: the prescaler is implemented as described above.
  - Undefined: `cfg_prescale` is ignored, there is no `pc` register, and a tick occurs every RUN cycle (behaves as P=0). The first increment is at N+2.

## Test plan
- Reset, then START with L=3, P=0, one-shot: `count` 1,2,3 at N+2..N+4; `done` one cycle at N+5; state DONE, `busy`=0, `count`=3.
- START with L=2, P=1, periodic for 20 cycles: `count` steps every 2 cycles 0,1,2,0; `done` every 6 cycles; `wraps`=3 after 18 cycles from first increment.
- PAUSE at `count`=5 (L=10, P=0), wait 7 cycles, PAUSE again: `count` stays 5 while paused; next increment 1 cycle after resume acceptance; `done` delayed by exactly 9 cycles.
- START while RUN, and PAUSE while IDLE: `err` pulses once each; `count`/state unchanged; `cmd_ready` low for one cycle after each acceptance.
- CLEAR on the same edge as the terminal tick (L=4): no `done`, `count`=0, `wraps`=0, IDLE.
- Deassert `rst_n` mid-count at `count`=100: `count`=0, `busy`=0 immediately; resumes correctly after a fresh START.

Source files
------------

// File: rtl/counter_ctrl.sv
// Command-sequenced 16-bit counter: START/STOP/PAUSE/CLEAR over valid/ready, prescaled ticks, one-shot or periodic limit.
// Optional prescaler under `COUNTER_CTRL_PRESCALE_EN`; without it a tick occurs every RUN cycle.
module counter_ctrl #(
    parameter int WIDTH = 16,
    parameter int PSW   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_mode,
    input  logic [PSW-1:0]   cfg_prescale,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       wraps
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic [7:0]       wraps_q, wraps_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             cmd_ready_q, cmd_ready_d;
    // Set for the single cycle after START so the first tick lands one cycle later than a resume.
    logic             arm_q, arm_d;
    logic             accept;
    logic             tick;

`ifdef COUNTER_CTRL_PRESCALE_EN
    logic [PSW-1:0]   presc_q, presc_d;
    logic [PSW-1:0]   pc_q, pc_d;
    assign tick = (state_q == ST_RUN) && !arm_q && (pc_q == presc_q);
`else
    logic             unused_prescale;
    assign unused_prescale = ^cfg_prescale;
    assign tick = (state_q == ST_RUN) && !arm_q;
`endif

    assign accept = cmd_valid && cmd_ready_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        limit_d     = limit_q;
        mode_d      = mode_q;
        wraps_d     = wraps_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        arm_d       = 1'b0;
        cmd_ready_d = !accept;
`ifdef COUNTER_CTRL_PRESCALE_EN
        presc_d     = presc_q;
        pc_d        = pc_q;
`endif
        if (accept) begin
            // An accepted command always wins over a tick on the same edge.
            case (cmd_op)
                OP_START: begin
                    if (state_q == ST_IDLE || state_q == ST_DONE) begin
                        limit_d = cfg_limit;
                        mode_d  = cfg_mode;
                        count_d = '0;
                        wraps_d = '0;
                        arm_d   = 1'b1;
                        state_d = ST_RUN;
`ifdef COUNTER_CTRL_PRESCALE_EN
                        presc_d = cfg_prescale;
                        pc_d    = '0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_STOP: begin
                    state_d = ST_IDLE;
                end
                OP_PAUSE: begin
                    if (state_q == ST_RUN) begin
                        state_d = ST_PAUSED;
                    end else if (state_q == ST_PAUSED) begin
                        state_d = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    wraps_d = '0;
`ifdef COUNTER_CTRL_PRESCALE_EN
                    pc_d    = '0;
`endif
                end
            endcase
        end else if (state_q == ST_RUN && !arm_q) begin
`ifdef COUNTER_CTRL_PRESCALE_EN
            if (pc_q == presc_q) begin
                pc_d = '0;
            end else begin
                pc_d = pc_q + 1'b1;
            end
`endif
            if (tick) begin
                if (count_q < limit_q) begin
                    count_d = count_q + 1'b1;
                end else if (mode_q) begin
                    count_d = '0;
                    done_d  = 1'b1;
                    if (wraps_q != 8'hFF) begin
                        wraps_d = wraps_q + 1'b1;
                    end
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
        end
        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            limit_q     <= '0;
            mode_q      <= 1'b0;
            wraps_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            arm_q       <= 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
            presc_q     <= '0;
            pc_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            limit_q     <= limit_d;
            mode_q      <= mode_d;
            wraps_q     <= wraps_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
            arm_q       <= arm_d;
`ifdef COUNTER_CTRL_PRESCALE_EN
            presc_q     <= presc_d;
            pc_q        <= pc_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign count     = count_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign wraps     = wraps_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: vector table plus hand sequences for pause, clear-on-terminal, periodic and mid-run reset.
module tb_counter_ctrl;

`ifdef COUNTER_CTRL_PRESCALE_EN
    localparam int PP = 2;
`else
    localparam int PP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cfg_limit = 16'd0;
    logic        cfg_mode = 1'b0;
    logic [7:0]  cfg_prescale = 8'd0;
    logic [15:0] count;
    logic        busy, done, err;
    logic [7:0]  wraps;

    int checks = 0;
    int errors = 0;

    counter_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cfg_limit(cfg_limit), .cfg_mode(cfg_mode),
        .cfg_prescale(cfg_prescale), .count(count), .busy(busy), .done(done),
        .err(err), .wraps(wraps)
    );

    always #5 clk = ~clk;

    typedef struct {
        int vld; int op; int lim; int mode;
        int c; int b; int d; int e; int r; int w;
    } vec_t;

    function automatic vec_t mk(input int vld, input int op, input int lim, input int mode,
                                input int c, input int b, input int d, input int e,
                                input int r, input int w);
        vec_t v;
        v.vld = vld; v.op = op; v.lim = lim; v.mode = mode;
        v.c = c; v.b = b; v.d = d; v.e = e; v.r = r; v.w = w;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int op, input int lim, input int mode, input int ps);
        cmd_valid    = 1'b1;
        cmd_op       = op[1:0];
        cfg_limit    = lim[15:0];
        cfg_mode     = (mode != 0);
        cfg_prescale = ps[7:0];
        cyc();
        cmd_valid    = 1'b0;
        cfg_limit    = 16'hFFFF;
        cfg_mode     = 1'b0;
        cfg_prescale = 8'hFF;
    endtask

    vec_t tbl[18];

    initial begin
        // START=0 STOP=1 PAUSE=2 CLEAR=3
        //            vld op lim mode   cnt busy done err rdy wraps
        tbl[0]  = mk(1, 0, 3, 0,        0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0,        0, 1, 0, 0, 1, 0);
        tbl[2]  = mk(0, 0, 0, 0,        1, 1, 0, 0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0,        2, 1, 0, 0, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0,        3, 1, 0, 0, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0,        3, 0, 1, 0, 1, 0);
        tbl[6]  = mk(0, 0, 0, 0,        3, 0, 0, 0, 1, 0);
        tbl[7]  = mk(1, 2, 0, 0,        3, 0, 0, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0,        3, 0, 0, 0, 1, 0);
        tbl[9]  = mk(1, 0, 5, 1,        0, 1, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0,        0, 1, 0, 0, 1, 0);
        tbl[11] = mk(0, 0, 0, 0,        1, 1, 0, 0, 1, 0);
        tbl[12] = mk(1, 0, 9, 0,        1, 1, 0, 1, 0, 0);
        tbl[13] = mk(0, 0, 0, 0,        2, 1, 0, 0, 1, 0);
        tbl[14] = mk(1, 1, 0, 0,        2, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0,        2, 0, 0, 0, 1, 0);
        tbl[16] = mk(1, 3, 0, 0,        0, 0, 0, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0,        0, 0, 0, 0, 1, 0);

        cyc();
        cyc();
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_wraps", int'(wraps), 0);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_count", int'(count), 0);

        // Vector table, P=0 throughout.
        for (int i = 0; i < 18; i++) begin
            cmd_valid    = (tbl[i].vld != 0);
            cmd_op       = tbl[i].op[1:0];
            cfg_limit    = tbl[i].lim[15:0];
            cfg_mode     = (tbl[i].mode != 0);
            cfg_prescale = 8'd0;
            cyc();
            cmd_valid = 1'b0;
            chk($sformatf("vec%0d_count", i), int'(count), tbl[i].c);
            chk($sformatf("vec%0d_busy", i), int'(busy), tbl[i].b);
            chk($sformatf("vec%0d_done", i), int'(done), tbl[i].d);
            chk($sformatf("vec%0d_err", i), int'(err), tbl[i].e);
            chk($sformatf("vec%0d_ready", i), int'(cmd_ready), tbl[i].r);
            chk($sformatf("vec%0d_wraps", i), int'(wraps), tbl[i].w);
        end

        // Periodic L=2, P=1: t ticks after edge k, ticks at k = 1 + j*PP.
        send(0, 2, 1, 1);
        for (int k = 1; k <= 24; k++) begin
            int t;
            bit tk;
            cyc();
            t  = (k - 1) / PP;
            tk = (k >= 2) && (((k - 1) % PP) == 0);
            chk($sformatf("per_k%0d_count", k), int'(count), t % 3);
            chk($sformatf("per_k%0d_done", k), int'(done), (tk && t > 0 && (t % 3) == 0) ? 1 : 0);
            chk($sformatf("per_k%0d_wraps", k), int'(wraps), t / 3);
        end
        send(1, 0, 0, 0);
        chk("per_stop_busy", int'(busy), 0);
        cyc();
        send(3, 0, 0, 0);
        chk("per_clear_wraps", int'(wraps), 0);
        cyc();

        // Pause at count 5 for 8 cycles, L=10, P=0: done at +6 after resume.
        send(0, 10, 0, 0);
        for (int k = 1; k <= 6; k++) cyc();
        chk("pause_pre_count", int'(count), 5);
        send(2, 0, 0, 0);
        chk("pause_enter_count", int'(count), 5);
        chk("pause_enter_busy", int'(busy), 1);
        for (int k = 1; k <= 7; k++) begin
            cyc();
            chk($sformatf("pause_hold%0d_count", k), int'(count), 5);
        end
        send(2, 0, 0, 0);
        chk("resume_edge_count", int'(count), 5);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk($sformatf("resume%0d_count", k), int'(count), (k <= 5) ? 5 + k : 10);
            chk($sformatf("resume%0d_done", k), int'(done), (k == 6) ? 1 : 0);
        end
        chk("pause_final_busy", int'(busy), 0);
        cyc();

        // CLEAR on the terminal edge of a periodic L=4 run after one wrap.
        send(0, 4, 1, 0);
        for (int k = 1; k <= 10; k++) cyc();
        chk("clr_pre_count", int'(count), 4);
        chk("clr_pre_wraps", int'(wraps), 1);
        send(3, 0, 0, 0);
        chk("clr_done", int'(done), 0);
        chk("clr_count", int'(count), 0);
        chk("clr_wraps", int'(wraps), 0);
        chk("clr_busy", int'(busy), 0);
        cyc();
        chk("clr_after_done", int'(done), 0);
        chk("clr_after_count", int'(count), 0);

        // Async reset mid-run at count 100.
        send(0, 200, 0, 0);
        for (int k = 1; k <= 101; k++) cyc();
        chk("mid_pre_count", int'(count), 100);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(cmd_ready), 1);
        chk("mid_rst_done", int'(done), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        send(0, 3, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk($sformatf("restart%0d_count", k), int'(count), (k < 2) ? 0 : ((k - 1 > 3) ? 3 : k - 1));
            chk($sformatf("restart%0d_done", k), int'(done), (k == 5) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
